// File: rtl/sitcpxg_rx_buf_reader.sv
// -----------------------------------------------------------------------------
// sitcpxg_rx_buf_reader
//
// Reader side of the SiTCPXG TCP receive buffer. The block owns the receive
// RAM, captures the byte-enabled writes SiTCPXG makes into it, and streams the
// stored bytes out as a 64-bit valid/ready byte stream. The consumed pointer
// (USER_RX_RADR) moves only when the sink accepts a beat, so TCP window space
// is returned only after the data has really been taken. A latched flush
// request is turned into a one-cycle buffer-clear handshake with SiTCPXG.
//
// Ports
//   XGMII_CLOCK      sole clock
//   RSTn             asynchronous active-low reset
//   USER_RX_WADR     SiTCP write byte address (bits [ADDR_W-1:3] select RAM word)
//   USER_RX_WENB     byte write enables, [7] = lane 0 = DAT[63:56]
//   USER_RX_WDAT     write data, big endian
//   USER_RX_SIZE     constant buffer size reported to SiTCP
//   USER_RX_RADR     consumed byte pointer
//   USER_RX_CLR_ENB  SiTCP permits a buffer clear
//   USER_RX_CLR_REQ  one-cycle buffer clear request
//   FLUSH_REQ        user request to discard buffer contents (latched)
//   OUT_VALID/READY  output beat handshake
//   OUT_DATA         bytes left-aligned, unused lanes zero
//   OUT_BYTES        number of valid bytes in the beat (1..8)
//   LEVEL            bytes written but not yet consumed
// -----------------------------------------------------------------------------
module sitcpxg_rx_buf_reader #(
    parameter int          ADDR_W  = 14,
    parameter logic [15:0] RX_SIZE = 16'd16368
) (
    input  logic              XGMII_CLOCK,
    input  logic              RSTn,
    input  logic [15:0]       USER_RX_WADR,
    input  logic [7:0]        USER_RX_WENB,
    input  logic [63:0]       USER_RX_WDAT,
    output logic [15:0]       USER_RX_SIZE,
    output logic [15:0]       USER_RX_RADR,
    input  logic              USER_RX_CLR_ENB,
    output logic              USER_RX_CLR_REQ,
    input  logic              FLUSH_REQ,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [63:0]       OUT_DATA,
    output logic [3:0]        OUT_BYTES,
    output logic [ADDR_W:0]   LEVEL
);

    localparam int WORD_W = ADDR_W - 3;
    localparam int DEPTH  = 1 << WORD_W;

    // Byte offset just past the last enabled lane. Lanes are contiguous, so the
    // last lane is the one driven by the lowest set enable bit.
    function automatic logic [3:0] lane_end(input logic [7:0] wenb);
        logic [3:0] e;
        e = 4'd0;
        for (int b = 7; b >= 0; b--) begin
            if (wenb[b]) begin
                e = 4'd8 - 4'(b);
            end
        end
        return e;
    endfunction

    logic [63:0]       mem_r [DEPTH];
    logic [63:0]       rd_data_r;

    logic [ADDR_W-1:0] fill_r;
    logic [ADDR_W-1:0] pf_r;
    logic [ADDR_W-1:0] radr_r;
    logic [ADDR_W:0]   level_r;
    logic              flush_r;
    logic              clr_req_r;

    // In-flight RAM read: offset and length of the beat being fetched
    logic              rd_valid_r;
    logic [2:0]        rd_off_r;
    logic [3:0]        rd_bytes_r;

    // Two-entry output FIFO; entry 0 drives the outputs directly
    logic              v0_r;
    logic [63:0]       data0_r;
    logic [3:0]        bytes0_r;
    logic              v1_r;
    logic [63:0]       data1_r;
    logic [3:0]        bytes1_r;

    logic              clr_fire_s;
    logic [7:0]        wr_lanes_s;
    logic [WORD_W-1:0] wr_word_s;
    logic              pop_s;
    logic [ADDR_W-1:0] diff_s;
    logic              empty_s;
    logic [3:0]        avail_s;
    logic [3:0]        n_s;
    logic [2:0]        occ_s;
    logic              rd_issue_s;
    logic [63:0]       push_data_s;
    logic [ADDR_W-1:0] fill_nxt_s;
    logic [ADDR_W-1:0] radr_nxt_s;
    logic [ADDR_W-1:0] pf_nxt_s;
    logic              unused_wadr_s;

    assign unused_wadr_s = ^{USER_RX_WADR[15:ADDR_W], USER_RX_WADR[2:0]};

    assign clr_fire_s = flush_r & USER_RX_CLR_ENB;
    // Writes arriving on the clear cycle are dropped together with the buffer
    assign wr_lanes_s = clr_fire_s ? 8'h00 : USER_RX_WENB;
    assign wr_word_s  = USER_RX_WADR[ADDR_W-1:3];
    assign pop_s      = v0_r & OUT_READY;

    assign diff_s  = fill_r - pf_r;
    assign empty_s = (diff_s == {ADDR_W{1'b0}});
    assign avail_s = 4'd8 - {1'b0, pf_r[2:0]};
    assign n_s     = (diff_s < {{(ADDR_W-4){1'b0}}, avail_s}) ? diff_s[3:0] : avail_s;

    // FIFO occupancy including the read in flight, less the beat leaving now
    assign occ_s      = {2'b00, v0_r} + {2'b00, v1_r} + {2'b00, rd_valid_r} - {2'b00, pop_s};
    assign rd_issue_s = ~empty_s & (occ_s < 3'd2) & ~clr_fire_s;

    // Left-align the fetched bytes and blank lanes beyond the beat length
    assign push_data_s = (rd_data_r << {rd_off_r, 3'b000})
                       & ~(64'hFFFF_FFFF_FFFF_FFFF >> {rd_bytes_r, 3'b000});

    // Next-state pointer values shared by the pointer registers and LEVEL
    always_comb begin
        fill_nxt_s = fill_r;
        radr_nxt_s = radr_r;
        pf_nxt_s   = pf_r;
        if (clr_fire_s) begin
            fill_nxt_s = {ADDR_W{1'b0}};
            radr_nxt_s = {ADDR_W{1'b0}};
            pf_nxt_s   = {ADDR_W{1'b0}};
        end else begin
            if (|wr_lanes_s) begin
                fill_nxt_s = {wr_word_s, 3'b000} + {{(ADDR_W-4){1'b0}}, lane_end(wr_lanes_s)};
            end else begin
                fill_nxt_s = fill_r;
            end
            if (pop_s) begin
                radr_nxt_s = radr_r + {{(ADDR_W-4){1'b0}}, bytes0_r};
            end else begin
                radr_nxt_s = radr_r;
            end
            if (rd_issue_s) begin
                pf_nxt_s = pf_r + {{(ADDR_W-4){1'b0}}, n_s};
            end else begin
                pf_nxt_s = pf_r;
            end
        end
    end

    // Receive RAM byte-lane writes
    always_ff @(posedge XGMII_CLOCK) begin
        for (int b = 0; b < 8; b++) begin
            if (wr_lanes_s[b]) begin
                mem_r[wr_word_s][8*b +: 8] <= USER_RX_WDAT[8*b +: 8];
            end
        end
    end

    // Receive RAM synchronous read port
    always_ff @(posedge XGMII_CLOCK) begin
        if (rd_issue_s) begin
            rd_data_r <= mem_r[pf_r[ADDR_W-1:3]];
        end
    end

    // Pointers, flush handshake, read tracking and output FIFO
    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            fill_r     <= {ADDR_W{1'b0}};
            pf_r       <= {ADDR_W{1'b0}};
            radr_r     <= {ADDR_W{1'b0}};
            level_r    <= {(ADDR_W+1){1'b0}};
            flush_r    <= 1'b0;
            clr_req_r  <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_off_r   <= 3'd0;
            rd_bytes_r <= 4'd0;
            v0_r       <= 1'b0;
            data0_r    <= 64'd0;
            bytes0_r   <= 4'd0;
            v1_r       <= 1'b0;
            data1_r    <= 64'd0;
            bytes1_r   <= 4'd0;
        end else begin
            fill_r    <= fill_nxt_s;
            pf_r      <= pf_nxt_s;
            radr_r    <= radr_nxt_s;
            level_r   <= {1'b0, fill_nxt_s - radr_nxt_s};
            clr_req_r <= clr_fire_s;
            flush_r   <= FLUSH_REQ | (flush_r & ~clr_fire_s);

            if (clr_fire_s) begin
                rd_valid_r <= 1'b0;
                v0_r       <= 1'b0;
                v1_r       <= 1'b0;
                data0_r    <= 64'd0;
                bytes0_r   <= 4'd0;
            end else begin
                rd_valid_r <= rd_issue_s;
                if (rd_issue_s) begin
                    rd_off_r   <= pf_r[2:0];
                    rd_bytes_r <= n_s;
                end
                if (pop_s) begin
                    if (v1_r) begin
                        data0_r  <= data1_r;
                        bytes0_r <= bytes1_r;
                        v0_r     <= 1'b1;
                        if (rd_valid_r) begin
                            data1_r  <= push_data_s;
                            bytes1_r <= rd_bytes_r;
                            v1_r     <= 1'b1;
                        end else begin
                            v1_r <= 1'b0;
                        end
                    end else if (rd_valid_r) begin
                        data0_r  <= push_data_s;
                        bytes0_r <= rd_bytes_r;
                        v0_r     <= 1'b1;
                    end else begin
                        v0_r <= 1'b0;
                    end
                end else if (rd_valid_r) begin
                    if (v0_r) begin
                        data1_r  <= push_data_s;
                        bytes1_r <= rd_bytes_r;
                        v1_r     <= 1'b1;
                    end else begin
                        data0_r  <= push_data_s;
                        bytes0_r <= rd_bytes_r;
                        v0_r     <= 1'b1;
                    end
                end
            end
        end
    end

    assign USER_RX_SIZE    = RX_SIZE;
    assign USER_RX_RADR    = {{(16-ADDR_W){1'b0}}, radr_r};
    assign USER_RX_CLR_REQ = clr_req_r;
    assign OUT_VALID       = v0_r;
    assign OUT_DATA        = data0_r;
    assign OUT_BYTES       = bytes0_r;
    assign LEVEL           = level_r;

endmodule

// File: tb/tb_sitcpxg_rx_buf_reader.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for sitcpxg_rx_buf_reader.
// -----------------------------------------------------------------------------
module tb_sitcpxg_rx_buf_reader;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       wadr;
    logic [7:0]        wenb;
    logic [63:0]       wdat;
    logic [15:0]       rx_size;
    logic [15:0]       radr;
    logic              clr_enb;
    logic              clr_req;
    logic              flush_req;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [3:0]        out_bytes;
    logic [ADDR_W:0]   level;

    int n_tests = 0;
    int n_fail  = 0;

    sitcpxg_rx_buf_reader #(.ADDR_W(ADDR_W), .RX_SIZE(16'd16368)) dut (
        .XGMII_CLOCK     (clk),
        .RSTn            (rst_n),
        .USER_RX_WADR    (wadr),
        .USER_RX_WENB    (wenb),
        .USER_RX_WDAT    (wdat),
        .USER_RX_SIZE    (rx_size),
        .USER_RX_RADR    (radr),
        .USER_RX_CLR_ENB (clr_enb),
        .USER_RX_CLR_REQ (clr_req),
        .FLUSH_REQ       (flush_req),
        .OUT_VALID       (out_valid),
        .OUT_READY       (out_ready),
        .OUT_DATA        (out_data),
        .OUT_BYTES       (out_bytes),
        .LEVEL           (level)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [15:0] a);
        return {a, ~a, a + 16'h1111, 16'h5A5A};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a beat, check it, then let the next edge accept it
    task automatic expect_beat(input string tag, input logic [63:0] data, input logic [3:0] nb);
        int w;
        w = 0;
        while (!out_valid && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, out_data, data);
        chk({tag, "_bytes"}, 64'(out_bytes), 64'(nb));
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rd;
        int errs;
        int seen;

        rst_n     = 1'b0;
        wadr      = 16'd0;
        wenb      = 8'h00;
        wdat      = 64'd0;
        clr_enb   = 1'b0;
        flush_req = 1'b0;
        out_ready = 1'b0;

        // 1: reset state
        repeat (5) step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_radr", 64'(radr), 64'd0);
        chk("rst_clr_req", 64'(clr_req), 64'd0);
        chk("rst_size", 64'(rx_size), 64'd16368);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_bytes", 64'(out_bytes), 64'd0);
        rst_n = 1'b1;
        step();

        // 2: two full words, latency and RADR progression
        out_ready = 1'b1;
        wadr = 16'd0; wenb = 8'hFF; wdat = pat(16'd0);
        step();
        chk("t2_e1_valid", 64'(out_valid), 64'd0);
        chk("t2_e1_level", 64'(level), 64'd8);
        wadr = 16'd8; wdat = pat(16'd8);
        step();
        wenb = 8'h00;
        chk("t2_e2_valid", 64'(out_valid), 64'd0);
        chk("t2_e2_level", 64'(level), 64'd16);
        step();
        chk("t2_b0_valid", 64'(out_valid), 64'd1);
        chk("t2_b0_data", out_data, pat(16'd0));
        chk("t2_b0_bytes", 64'(out_bytes), 64'd8);
        chk("t2_b0_radr", 64'(radr), 64'd0);
        step();
        chk("t2_b1_valid", 64'(out_valid), 64'd1);
        chk("t2_b1_data", out_data, pat(16'd8));
        chk("t2_b1_radr", 64'(radr), 64'd8);
        step();
        chk("t2_end_valid", 64'(out_valid), 64'd0);
        chk("t2_end_radr", 64'(radr), 64'd16);
        chk("t2_end_level", 64'(level), 64'd0);

        // 3: partial words, short beats at an offset
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t3_rst_radr", 64'(radr), 64'd0);
        wadr = 16'd0; wenb = 8'hE0; wdat = 64'h1122_3300_0000_0000;
        step();
        wenb = 8'h00;
        expect_beat("t3_head", 64'h1122_3300_0000_0000, 4'd3);
        chk("t3_head_radr", 64'(radr), 64'd3);
        wadr = 16'd3; wenb = 8'h1F; wdat = 64'h0000_00AA_BBCC_DDEE;
        step();
        wenb = 8'h00;
        expect_beat("t3_tail", 64'hAABB_CCDD_EE00_0000, 4'd5);
        chk("t3_tail_radr", 64'(radr), 64'd8);
        chk("t3_tail_level", 64'(level), 64'd0);

        // 4: stream up to the top of the buffer, then wrap
        exp_rd = 8;
        errs   = 0;
        for (int a = 8; a < 16376; a += 8) begin
            wadr = 16'(a); wenb = 8'hFF; wdat = pat(16'(a));
            step();
            if (out_valid) begin
                if (out_data !== pat(16'(exp_rd)) || out_bytes !== 4'd8) errs++;
                exp_rd += 8;
            end
        end
        wenb = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) begin
                if (out_data !== pat(16'(exp_rd)) || out_bytes !== 4'd8) errs++;
                exp_rd += 8;
            end
        end
        chk("t4_bulk_errs", 64'(errs), 64'd0);
        chk("t4_bulk_count", 64'(exp_rd), 64'd16376);
        chk("t4_pre_radr", 64'(radr), 64'd16376);
        chk("t4_pre_level", 64'(level), 64'd0);
        wadr = 16'd16376; wenb = 8'hFF; wdat = pat(16'd16376);
        step();
        wadr = 16'd0; wdat = 64'hDEAD_BEEF_0123_4567;
        step();
        wenb = 8'h00;
        expect_beat("t4_top", pat(16'd16376), 4'd8);
        chk("t4_top_radr", 64'(radr), 64'd0);
        expect_beat("t4_wrap", 64'hDEAD_BEEF_0123_4567, 4'd8);
        chk("t4_wrap_radr", 64'(radr), 64'd8);
        chk("t4_wrap_level", 64'(level), 64'd0);

        // 5: backpressure then full-rate drain
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wadr = 16'(8 + 8*k); wenb = 8'hFF; wdat = pat(16'(8 + 8*k));
            step();
        end
        wenb = 8'h00;
        repeat (4) step();
        chk("t5_hold_valid", 64'(out_valid), 64'd1);
        chk("t5_hold_data", out_data, pat(16'd8));
        chk("t5_hold_radr", 64'(radr), 64'd8);
        chk("t5_hold_level", 64'(level), 64'd32);
        repeat (3) step();
        chk("t5_stable_data", out_data, pat(16'd8));
        chk("t5_stable_bytes", 64'(out_bytes), 64'd8);
        chk("t5_stable_radr", 64'(radr), 64'd8);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            chk("t5_drain_valid", 64'(out_valid), 64'd1);
            chk("t5_drain_data", out_data, pat(16'(8 + 8*k)));
            chk("t5_drain_radr", 64'(radr), 64'(8 + 8*k));
        end
        step();
        chk("t5_end_valid", 64'(out_valid), 64'd0);
        chk("t5_end_radr", 64'(radr), 64'd40);

        // 6: flush waits for CLR_ENB, then clears everything
        out_ready = 1'b0;
        wadr = 16'd40; wenb = 8'hFF; wdat = pat(16'd40);
        step();
        wadr = 16'd48; wdat = pat(16'd48);
        step();
        wenb = 8'h00;
        repeat (4) step();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clr_req) seen++;
        end
        chk("t6_wait_clr", 64'(seen), 64'd0);
        chk("t6_wait_valid", 64'(out_valid), 64'd1);
        chk("t6_wait_data", out_data, pat(16'd40));
        chk("t6_wait_level", 64'(level), 64'd16);
        clr_enb = 1'b1;
        wadr = 16'h0100; wenb = 8'hFF; wdat = pat(16'h0100);
        step();
        wenb = 8'h00;
        chk("t6_clr_req", 64'(clr_req), 64'd1);
        chk("t6_clr_radr", 64'(radr), 64'd0);
        chk("t6_clr_level", 64'(level), 64'd0);
        chk("t6_clr_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (clr_req) seen++;
        end
        chk("t6_clr_once", 64'(seen), 64'd0);
        chk("t6_ignored_wr_level", 64'(level), 64'd0);
        chk("t6_post_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        wadr = 16'd0; wenb = 8'hFF; wdat = 64'h0102_0304_0506_0708;
        step();
        wenb = 8'h00;
        expect_beat("t6_after", 64'h0102_0304_0506_0708, 4'd8);
        chk("t6_after_radr", 64'(radr), 64'd8);

        // 7: asynchronous reset with a beat pending
        out_ready = 1'b0;
        wadr = 16'd8; wenb = 8'hFF; wdat = pat(16'd99);
        step();
        wenb = 8'h00;
        repeat (4) step();
        chk("t7_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_valid", 64'(out_valid), 64'd0);
        chk("t7_radr", 64'(radr), 64'd0);
        chk("t7_level", 64'(level), 64'd0);
        chk("t7_data", out_data, 64'd0);
        chk("t7_bytes", 64'(out_bytes), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
